// File: rtl/spi_arbiter.sv
// Round-robin arbiter that lets four requesters share one SPI master, one byte per grant.
// Each grant runs LAUNCH -> WAIT_LOW -> WAIT_HIGH -> DONE, with a timeout guarding both waits.
module spi_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [31:0] req_data,
  output logic [3:0]  ack,
  output logic [7:0]  rsp_data,
  output logic        rsp_err,
  output logic        busy,
  output logic [1:0]  grant_id,
  output logic        m_start,
  output logic [7:0]  m_din,
  input  logic        m_cs,
  input  logic [7:0]  m_dout
);

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_LOW, WAIT_HIGH, DONE} state_e;

  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic [1:0]  last_q, last_d;
  logic [7:0]  tx_q, tx_d;
  logic [7:0]  rsp_q, rsp_d;
  logic        err_q, err_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  winner;

  // Search upward from last_grant+1; descending loop lets the nearest requester win.
  always_comb begin
    winner = last_q;
    for (int k = 4; k >= 1; k--) begin
      if (req[last_q + 2'(k)]) winner = last_q + 2'(k);
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    tx_d    = tx_q;
    rsp_d   = rsp_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (|req) begin
          grant_d = winner;
          tx_d    = req_data[{winner, 3'b000} +: 8];
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        cnt_d   = '0;
        state_d = WAIT_LOW;
      end
      WAIT_LOW: begin
        if (!m_cs) begin
          cnt_d   = '0;
          state_d = WAIT_HIGH;
        end else if (cnt_q == TimeoutLast) begin
          err_d   = 1'b1;
          rsp_d   = 8'h00;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      WAIT_HIGH: begin
        // A completing transfer beats a timeout landing on the same edge.
        if (m_cs) begin
          err_d   = 1'b0;
          rsp_d   = m_dout;
          state_d = DONE;
        end else if (cnt_q == TimeoutLast) begin
          err_d   = 1'b1;
          rsp_d   = 8'h00;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DONE: begin
        last_d  = grant_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= 2'd0;
      last_q  <= 2'd3;
      tx_q    <= 8'h00;
      rsp_q   <= 8'h00;
      err_q   <= 1'b0;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      tx_q    <= tx_d;
      rsp_q   <= rsp_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ack      = (state_q == DONE) ? (4'b0001 << grant_q) : 4'b0000;
  assign m_start  = (state_q == LAUNCH);
  assign busy     = (state_q != IDLE);
  assign m_din    = tx_q;
  assign grant_id = grant_q;
  assign rsp_data = rsp_q;
  assign rsp_err  = err_q;

endmodule

// File: doc/spi_arbiter.md
SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 Parameter: TIMEOUT, 255, max cycles spent in either wait state before a transfer is abandoned (range 1..65535).
REQ-002 Port: clk  input  1  single clock; all logic on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: req  input  4  per-requester level request; requester i holds req[i] until it sees ack[i].
REQ-005 Port: req_data  input  32  packed TX bytes; byte i = req_data[8*i+7:8*i].
REQ-006 Port: ack  output  4  one-cycle completion pulse to the granted requester.
REQ-007 Port: rsp_data  output  8  received byte; valid only while ack is nonzero.
REQ-008 Port: rsp_err  output  1  timeout flag; valid only while ack is nonzero.
REQ-009 Port: busy  output  1  high whenever state is not IDLE.
REQ-010 Port: grant_id  output  2  index of the current or most recent winner.
REQ-011 Port: m_start  output  1  start strobe to the shared SPI master.
REQ-012 Port: m_din  output  8  TX byte to the SPI master.
REQ-013 Port: m_cs  input  1  SPI master chip select; low = transfer in progress.
REQ-014 Port: m_dout  input  8  SPI master RX byte; valid once m_cs has returned high after a transfer.

Function
REQ-015 States SHALL be IDLE, LAUNCH, WAIT_LOW, WAIT_HIGH, DONE; only the transitions listed here SHALL occur.
REQ-016 IDLE: if any req bit is high, the winner SHALL be chosen round-robin, searching upward (mod 4) from last_grant+1.
REQ-017 On that same edge: grant_id <= winner, the winner's byte latched into a TX holding register, state <= LAUNCH.
REQ-018 Requests arriving while not in IDLE SHALL be held pending and SHALL NOT alter the current grant or latched byte.
REQ-019 LAUNCH lasts exactly one cycle: m_start=1 and m_din=latched byte; next state WAIT_LOW.
REQ-020 m_start SHALL be 0 in every state other than LAUNCH; m_din SHALL hold the latched byte from LAUNCH until the next grant.
REQ-021 WAIT_LOW: on sampling m_cs==0, go to WAIT_HIGH and clear the timeout counter.
REQ-022 WAIT_HIGH: on sampling m_cs==1, capture m_dout into rsp_data and go to DONE with the error flag clear.
REQ-023 A 16-bit timeout counter SHALL clear on entry to each wait state and increment every cycle spent there.
REQ-024 If the counter reaches TIMEOUT-1 in either wait state without the exit condition, go to DONE with rsp_err=1 and rsp_data=0x00.
REQ-025 If the exit condition and timeout occur in the same cycle, the exit condition SHALL win (rsp_err=0).
REQ-026 DONE lasts exactly one cycle: ack[grant_id]=1 (other ack bits 0) with rsp_data/rsp_err driven; last_grant <= grant_id; next state IDLE.
REQ-027 Latency: req sampled in IDLE at edge N gives m_start high during cycle N+1; ack rises in the cycle after m_cs is sampled high.
REQ-028 Minimum IDLE dwell SHALL be one cycle between DONE and the next LAUNCH, so back-to-back grants re-arbitrate.
REQ-029 Deasserting req[grant_id] mid-transfer SHALL NOT abort the transfer; the ack pulse is still issued.
REQ-030 Fairness: under continuous requests from all four requesters, grants SHALL follow 0,1,2,3,0,...

Reset
REQ-031 While reset is high at a clock edge: state <= IDLE; ack=0; rsp_data=0x00; rsp_err=0; m_start=0; m_din=0x00; grant_id=0; timeout counter=0.
REQ-032 Reset SHALL set last_grant=3 so that requester 0 has first priority.
REQ-033 Reset asserted mid-transfer SHALL abandon the transaction without an ack pulse.

Verification
REQ-034 Single request: req=0001, byte0=0xA5, master model echoes 0x3C -> one m_start pulse with m_din=0xA5, then ack=0001 with rsp_data=0x3C and rsp_err=0.
REQ-035 Contention: req=1111 held, distinct bytes -> m_din sequence byte0, byte1, byte2, byte3, byte0 and ack order 0,1,2,3,0.
REQ-036 Late arrival: req[2] rises while requester 1 is in WAIT_HIGH -> requester 1 completes unchanged; requester 2 is granted next.
REQ-037 Timeout: TIMEOUT=8, m_cs held high after launch -> ack pulse exactly 8 cycles after entering WAIT_LOW, with rsp_err=1 and rsp_data=0x00.
REQ-038 Reset in WAIT_HIGH -> all outputs at reset values the next cycle, no ack; a subsequent req=1000 sees requester 3 granted normally.
REQ-039 Withdrawn request: req[0] dropped after LAUNCH -> transfer completes and ack=0001 is still pulsed once.
